// File: rtl/jk_pkg.sv
// Shared J/K command encodings and command-counter width for the debouncer and the flip-flop stage.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  localparam int CMD_COUNT_W = 8;

endpackage

// File: rtl/debounce_filter.sv
// One button channel: 2-flop synchroniser, persistence filter, rising-edge detect.
// o_Press is high for the single cycle after the filtered level rises.
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Raw,
  output logic o_Level,
  output logic o_Press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Flip on the edge where the count would reach DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic             level_prev;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_meta  <= 1'b0;
      sync_q     <= 1'b0;
      level_prev <= 1'b0;
      o_Level    <= 1'b0;
      cnt        <= '0;
    end else begin
      sync_meta  <= i_Raw;
      sync_q     <= sync_meta;
      level_prev <= o_Level;
      if (sync_q == o_Level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        o_Level <= ~o_Level;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_Press = o_Level & ~level_prev;

endmodule

// File: rtl/jk_command_debouncer.sv
// Merges three debounced button presses into one registered J/K pulse plus a
// wrapping command counter that updates the cycle after each pulse.
module jk_command_debouncer
  import jk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic                   i_Set,
  input  logic                   i_Clr,
  input  logic                   i_Tgl,
  output logic                   o_J,
  output logic                   o_K,
  output logic                   o_Cmd_Valid,
  output logic [CMD_COUNT_W-1:0] o_Cmd_Count
);

  logic set_level, set_press;
  logic clr_level, clr_press;
  logic tgl_level, tgl_press;
  logic set_cmd, clr_cmd, tgl_cmd;
  logic [1:0] jk_next;

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Raw(i_Set), .o_Level(set_level), .o_Press(set_press)
  );
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Raw(i_Clr), .o_Level(clr_level), .o_Press(clr_press)
  );
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_tgl (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Raw(i_Tgl), .o_Level(tgl_level), .o_Press(tgl_press)
  );

  assign set_cmd = set_press & set_level;
  assign clr_cmd = clr_press & clr_level;
  assign tgl_cmd = tgl_press & tgl_level;

  // Set and clear landing together is exactly the JK toggle.
  always_comb begin
    jk_next = JK_HOLD;
    if (tgl_cmd || (set_cmd && clr_cmd)) begin
      jk_next = JK_TOGGLE;
    end else if (set_cmd) begin
      jk_next = JK_SET;
    end else if (clr_cmd) begin
      jk_next = JK_RESET;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_J         <= 1'b0;
      o_K         <= 1'b0;
      o_Cmd_Valid <= 1'b0;
      o_Cmd_Count <= '0;
    end else begin
      o_J         <= jk_next[1];
      o_K         <= jk_next[0];
      o_Cmd_Valid <= (jk_next != JK_HOLD);
      if (o_Cmd_Valid) begin
        o_Cmd_Count <= o_Cmd_Count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jk_command_debouncer.sv
// Directed bench for jk_command_debouncer with a cycle-stamped pulse scoreboard.
module tb_jk_command_debouncer;

  localparam int D = 4;

  typedef struct {
    int cyc;
    bit j;
    bit k;
  } exp_t;

  logic       i_Clk = 1'b0;
  logic       i_Rst_n;
  logic       i_Set, i_Clr, i_Tgl;
  logic       o_J, o_K, o_Cmd_Valid;
  logic [7:0] o_Cmd_Count;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [7:0] exp_cnt = 8'h00;

  jk_command_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Set(i_Set), .i_Clr(i_Clr), .i_Tgl(i_Tgl),
    .o_J(o_J), .o_K(o_K), .o_Cmd_Valid(o_Cmd_Valid), .o_Cmd_Count(o_Cmd_Count)
  );

  always #5 i_Clk = ~i_Clk;
  always @(posedge i_Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  // Raw input driven just after edge cyc: first sampling edge is cyc+1,
  // pulse is visible after edge cyc+1+2+D.
  task automatic expect_pulse(input bit j, input bit k);
    exp_t e;
    e.cyc = cyc + 3 + D;
    e.j   = j;
    e.k   = k;
    sb.push_back(e);
  endtask

  always @(negedge i_Clk) begin
    if (!i_Rst_n) begin
      chk("reset_outputs", {21'd0, o_J, o_K, o_Cmd_Valid, o_Cmd_Count}, 32'd0);
      exp_cnt = 8'h00;
    end else begin
      logic [2:0] exp_jkv;
      bit due;
      due     = (sb.size() > 0) && (sb[0].cyc == cyc);
      exp_jkv = due ? {sb[0].j, sb[0].k, 1'b1} : 3'b000;
      chk($sformatf("jkv@%0d", cyc), {29'd0, o_J, o_K, o_Cmd_Valid}, {29'd0, exp_jkv});
      chk($sformatf("count@%0d", cyc), {24'd0, o_Cmd_Count}, {24'd0, exp_cnt});
      if (due) begin
        void'(sb.pop_front());
        exp_cnt = exp_cnt + 8'd1;
      end
    end
  end

  initial begin
    i_Rst_n = 1'b0;
    i_Set = 1'b0; i_Clr = 1'b0; i_Tgl = 1'b0;
    tick(3);
    i_Rst_n = 1'b1;
    tick(50);

    // Clean press held 30 cycles: one 10 pulse.
    i_Set = 1'b1; expect_pulse(1'b1, 1'b0);
    tick(30);
    i_Set = 1'b0;
    tick(12);

    // Bounce on toggle: 1/2/3-cycle highs, then a steady hold.
    i_Tgl = 1'b1; tick(1); i_Tgl = 1'b0; tick(1);
    i_Tgl = 1'b1; tick(2); i_Tgl = 1'b0; tick(1);
    i_Tgl = 1'b1; tick(3); i_Tgl = 1'b0; tick(1);
    i_Tgl = 1'b1; expect_pulse(1'b1, 1'b1);
    tick(20);
    i_Tgl = 1'b0;
    tick(12);

    // Simultaneous set and clear merge into one toggle.
    i_Set = 1'b1; i_Clr = 1'b1; expect_pulse(1'b1, 1'b1);
    tick(20);
    i_Set = 1'b0; i_Clr = 1'b0;
    tick(12);

    // Different channels one cycle apart stay separate pulses.
    i_Set = 1'b1; expect_pulse(1'b1, 1'b0);
    tick(1);
    i_Clr = 1'b1; expect_pulse(1'b0, 1'b1);
    tick(20);
    i_Set = 1'b0; i_Clr = 1'b0;
    tick(12);

    // Reset while the set filter count sits at 3: nothing emerges.
    i_Set = 1'b1;
    tick(5);
    i_Rst_n = 1'b0;
    sb.delete();
    i_Set = 1'b0;
    tick(3);
    i_Rst_n = 1'b1;
    tick(20);

    // Button held across reset release is a fresh press.
    i_Rst_n = 1'b0;
    i_Set = 1'b1;
    tick(3);
    i_Rst_n = 1'b1; expect_pulse(1'b1, 1'b0);
    tick(20);
    i_Set = 1'b0;
    tick(12);

    // 257 clear presses from a fresh reset: counter wraps to 0x01.
    i_Rst_n = 1'b0;
    tick(2);
    i_Rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < 257; i++) begin
      i_Clr = 1'b1; expect_pulse(1'b0, 1'b1);
      tick(10);
      i_Clr = 1'b0;
      tick(10);
    end
    tick(5);
    chk("wrap_count", {24'd0, o_Cmd_Count}, 32'h01);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
